// File: rtl/i2c_bus_cond_detector.sv
// I2C receive-side bus condition detector: synchronises and deglitches SCL/SDA,
// detects START / repeated START / STOP, tracks bus ownership and frames bits.
module i2c_bus_cond_detector #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       start_det,
    output logic       rstart_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic       scl_rise,
    output logic       sda_bit,
    output logic [3:0] bit_cnt,
    output logic       byte_done
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned BIT_W = 4;
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_LEN - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(8);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Line index 0 = SCL, 1 = SDA
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       filt;
    logic [1:0]       prev;
    logic [CNT_W-1:0] fcnt [2];

    logic f_scl, f_sda, p_scl, p_sda;
    logic start_c, stop_c, rise_c;

    state_t           state, state_nxt;
    logic             start_nxt, rstart_nxt, stop_nxt, rise_nxt, done_nxt;
    logic             sda_bit_nxt;
    logic [BIT_W-1:0] bit_cnt_nxt;

    // Two-stage synchroniser for the asynchronous bus lines
    always_ff @(posedge mclk) begin
        if (rst) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {sda_in, scl_in};
            sync2 <= sync1;
        end
    end

    // Deglitch filter: accept a new level only after FILT_LEN consecutive differing samples
    always_ff @(posedge mclk) begin
        if (rst) begin
            filt <= 2'b11;
            prev <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                fcnt[i] <= '0;
            end
        end else begin
            prev <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_LAST) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign f_scl = filt[0];
    assign f_sda = filt[1];
    assign p_scl = prev[0];
    assign p_sda = prev[1];

    // SDA transitions are conditions only while SCL has been high for both samples
    assign start_c = p_sda & ~f_sda & p_scl & f_scl;
    assign stop_c  = ~p_sda & f_sda & p_scl & f_scl;
    assign rise_c  = ~p_scl & f_scl;

    // FSM state register
    always_ff @(posedge mclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output decode; START/STOP take priority over an SCL rise
    always_comb begin
        state_nxt   = state;
        start_nxt   = 1'b0;
        rstart_nxt  = 1'b0;
        stop_nxt    = 1'b0;
        rise_nxt    = 1'b0;
        done_nxt    = 1'b0;
        sda_bit_nxt = sda_bit;
        bit_cnt_nxt = bit_cnt;
        case (state)
            IDLE: begin
                if (start_c) begin
                    start_nxt   = 1'b1;
                    bit_cnt_nxt = '0;
                    state_nxt   = ACTIVE;
                end else if (stop_c) begin
                    stop_nxt = 1'b1;
                end
            end
            ACTIVE: begin
                if (start_c) begin
                    rstart_nxt  = 1'b1;
                    bit_cnt_nxt = '0;
                end else if (stop_c) begin
                    stop_nxt    = 1'b1;
                    bit_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end else if (rise_c) begin
                    rise_nxt    = 1'b1;
                    sda_bit_nxt = f_sda;
                    if (bit_cnt == LAST_BIT) begin
                        done_nxt    = 1'b1;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge mclk) begin
        if (rst) begin
            start_det  <= 1'b0;
            rstart_det <= 1'b0;
            stop_det   <= 1'b0;
            scl_rise   <= 1'b0;
            byte_done  <= 1'b0;
            bus_busy   <= 1'b0;
            sda_bit    <= 1'b1;
            bit_cnt    <= '0;
        end else begin
            start_det  <= start_nxt;
            rstart_det <= rstart_nxt;
            stop_det   <= stop_nxt;
            scl_rise   <= rise_nxt;
            byte_done  <= done_nxt;
            bus_busy   <= (state_nxt == ACTIVE);
            sda_bit    <= sda_bit_nxt;
            bit_cnt    <= bit_cnt_nxt;
        end
    end

endmodule
